// File: rtl/sram_controller.sv
// sram_controller: memory-stage responder that serves one 32-bit load or
// store as two consecutive 16-bit SRAM half-word accesses (low half first).
// The pipeline is frozen through ready until the whole access completes.
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter value on the final cycle of a half-word phase.
  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [16:0] addr_lat;
  logic [31:0] data_lat;
  logic        op_write;

  logic        request;
  logic        phase_active;
  logic        phase_last;

  // Byte-lane and out-of-range address bits have no meaning for this SRAM.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  assign request      = mem_read | mem_write;
  assign phase_active = (state == LOW) || (state == HIGH);
  assign phase_last   = phase_active && (cnt == LAST_CNT);

  // Next-state selection: each half-word phase ends on its last counted cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (request)    state_nxt = LOW;
      LOW:     if (phase_last) state_nxt = HIGH;
      HIGH:    if (phase_last) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Phase counter restarts on every state entry so it never wraps in a phase.
  always_comb begin
    cnt_nxt = '0;
    if (phase_active && (state_nxt == state)) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request once in IDLE; later input changes cannot alter it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_lat <= '0;
      data_lat <= '0;
      op_write <= 1'b0;
    end else if ((state == IDLE) && request) begin
      addr_lat <= address[18:2];
      data_lat <= write_data;
      op_write <= mem_write;
    end
  end

  // SRAM address/data are loaded one cycle ahead of each phase so they are
  // stable for the whole phase, and simply hold through DONE and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else if ((state == IDLE) && request) begin
      sram_addr   <= {address[18:2], 1'b0};
      sram_dq_out <= write_data[15:0];
    end else if ((state == LOW) && phase_last) begin
      sram_addr   <= {addr_lat, 1'b1};
      sram_dq_out <= data_lat[31:16];
    end
  end

  // Load result: each half is sampled on the last cycle of its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!op_write && phase_last) begin
      if (state == LOW) begin
        read_data[15:0] <= sram_dq_in;
      end else begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

  // Bus drive and write strobe; the strobe is released on each phase's last
  // cycle so the data is held past the rising edge of we_n.
  always_comb begin
    sram_dq_oe = op_write && phase_active;
    sram_we_n  = !(op_write && phase_active && (cnt != LAST_CNT));
  end

  // Pipeline handshake: free when idle with nothing pending, or on completion.
  always_comb begin
    ready = ((state == IDLE) && !request) || (state == DONE);
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and randomized checks of sram_controller with
// PHASE_CYCLES=2 (main instance) and PHASE_CYCLES=1 (read-only instance).
module tb_sram_controller;

  localparam int unsigned PC0 = 2;
  localparam int unsigned PC1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic [31:0] rdata0;
  logic        rdy0, oe0, wen0;
  logic [17:0] sa0;
  logic [15:0] dqo0, dqi0;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] a1 = '0, d1 = '0;
  logic [31:0] rdata1;
  logic        rdy1, oe1, wen1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;

  sram_controller #(.PHASE_CYCLES(PC0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .address(a0),
    .write_data(d0), .read_data(rdata0), .ready(rdy0), .sram_addr(sa0),
    .sram_dq_out(dqo0), .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(wen0)
  );

  sram_controller #(.PHASE_CYCLES(PC1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .address(a1),
    .write_data(d1), .read_data(rdata1), .ready(rdy1), .sram_addr(sa1),
    .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(wen1)
  );

  // Behavioural SRAMs: sram0 is written by its controller's strobe,
  // sram1 is preloaded and only read.
  logic [15:0] sram0 [0:262143];
  logic [15:0] sram1 [0:262143];
  assign dqi0 = sram0[sa0];
  assign dqi1 = sram1[sa1];
  always @(posedge clk) if (oe0 && !wen0) sram0[sa0] <= dqo0;

  // Word-level reference: 32-bit contents keyed by word index address[18:2].
  logic [31:0] ref_word [int];
  logic [31:0] pre1     [int];
  logic [31:0] ref_rd   [2];
  logic [17:0] last_sa  [2];

  logic sel = 1'b0;
  logic        rdy_m, oe_m, wen_m;
  logic [31:0] rdata_m;
  logic [17:0] sa_m;
  logic [15:0] dqo_m;
  assign rdy_m   = sel ? rdy1   : rdy0;
  assign oe_m    = sel ? oe1    : oe0;
  assign wen_m   = sel ? wen1   : wen0;
  assign rdata_m = sel ? rdata1 : rdata0;
  assign sa_m    = sel ? sa1    : sa0;
  assign dqo_m   = sel ? dqo1   : dqo0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
    else     begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
  endtask

  function automatic logic [31:0] model_read(input int idx);
    return sel ? pre1[idx] : ref_word[idx];
  endfunction

  // One cycle with no request; outputs must be quiet and holding.
  task automatic idle_cycle();
    drive(1'b0, 1'b0, $urandom(), $urandom());
    @(posedge clk); #1;
    chk("idle_ready", rdy_m, 1);
    chk("idle_we_n", wen_m, 1);
    chk("idle_oe", oe_m, 0);
    chk("idle_rdata", rdata_m, ref_rd[sel]);
    chk("idle_sa_hold", sa_m, last_sa[sel]);
  endtask

  // Full request. Entry: #1 after an edge, in IDLE (in_done=0) or in
  // DONE (in_done=1, request presented there and seen in the next IDLE).
  // Exit: #1 into the DONE cycle with the request still driven.
  task automatic do_op(input bit in_done, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input bit perturb);
    int unsigned pc;
    int done_cyc;
    int idx;
    logic [17:0] lo, hi;
    logic [31:0] exp_word;
    pc = sel ? PC1 : PC0;
    done_cyc = -1;
    lo = {a[18:2], 1'b0};
    hi = {a[18:2], 1'b1};
    idx = int'(a[18:2]);
    drive(rd, wr, a, d);
    if (in_done) begin @(posedge clk); #1; end
    else #1;
    chk("c0_ready", rdy_m, 0);
    chk("c0_we_n", wen_m, 1);
    chk("c0_oe", oe_m, 0);
    chk("c0_sa_hold", sa_m, last_sa[sel]);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (rdy_m) begin done_cyc = cyc; break; end
      if (cyc <= int'(2 * pc)) begin
        int k, j;
        bit hi_ph;
        k = cyc - 1;
        hi_ph = (k >= int'(pc));
        j = hi_ph ? k - int'(pc) : k;
        chk("ph_sa", sa_m, hi_ph ? hi : lo);
        chk("ph_oe", oe_m, wr);
        chk("ph_we_n", wen_m, !(wr && (j != int'(pc) - 1)));
        if (wr) chk("ph_dq", dqo_m, hi_ph ? d[31:16] : d[15:0]);
      end
      if (cyc == 1 && perturb) drive(1'b0, 1'b0, a ^ 32'h0001_0FF0, ~d);
    end
    chk("latency", done_cyc, 2 * pc + 1);
    if (rd && !wr) ref_rd[sel] = model_read(idx);
    if (wr) ref_word[idx] = d;
    chk("done_rdata", rdata_m, ref_rd[sel]);
    chk("done_sa", sa_m, hi);
    chk("done_we_n", wen_m, 1);
    chk("done_oe", oe_m, 0);
    if (wr && !sel) begin
      exp_word = ref_word[idx];
      chk("mem_lo", sram0[lo], exp_word[15:0]);
      chk("mem_hi", sram0[hi], exp_word[31:16]);
    end
    last_sa[sel] = hi;
  endtask

  logic [16:0] pool [8] = '{17'h00004, 17'h00102, 17'h00103, 17'h1FFFF,
                            17'h00000, 17'h0ABCD, 17'h10000, 17'h05555};

  initial begin
    logic [31:0] r, a, old;
    logic [16:0] kk;
    ref_rd[0] = '0; ref_rd[1] = '0;
    last_sa[0] = '0; last_sa[1] = '0;
    pre1[32'h1FFFF] = 32'hF00D_C0DE;
    pre1[8]         = 32'h0123_4567;
    pre1[32'h0AAAA] = 32'h89AB_CDEF;
    pre1[0]         = 32'h5A5A_0F0F;
    foreach (pre1[k]) begin
      kk = k[16:0];
      old = pre1[k];
      sram1[{kk, 1'b0}] = old[15:0];
      sram1[{kk, 1'b1}] = old[31:16];
    end

    // Reset state with reset held low.
    #2;
    chk("rst_rdata0", rdata0, 0);  chk("rst_ready0", rdy0, 1);
    chk("rst_sa0", sa0, 0);        chk("rst_dq0", dqo0, 0);
    chk("rst_oe0", oe0, 0);        chk("rst_we_n0", wen0, 1);
    chk("rst_rdata1", rdata1, 0);  chk("rst_ready1", rdy1, 1);
    chk("rst_sa1", sa1, 0);        chk("rst_dq1", dqo1, 0);
    chk("rst_oe1", oe1, 0);        chk("rst_we_n1", wen1, 1);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Directed sequence on the PHASE_CYCLES=2 instance.
    sel = 1'b0;
    idle_cycle();
    do_op(0, 0, 1, 32'h0000_0408, 32'h1234_5678, 0);
    idle_cycle();
    do_op(0, 1, 0, 32'h0000_0408, '0, 0);
    idle_cycle();
    do_op(0, 0, 1, 32'h0000_0408, 32'hDEAD_BEEF, 0);
    idle_cycle();
    do_op(0, 1, 0, 32'h0000_0408, '0, 0);
    chk("rd_deadbeef", rdata0, 32'hDEAD_BEEF);
    idle_cycle();
    do_op(0, 1, 1, 32'h0000_0408, 32'hA5A5_5A5A, 0);
    chk("both_keeps_rd", rdata0, 32'hDEAD_BEEF);
    do_op(1, 1, 0, 32'h0000_0408, '0, 0);
    do_op(1, 0, 1, 32'h0000_040C, 32'h0BAD_F00D, 0);
    do_op(1, 1, 0, 32'h0000_040C, '0, 0);
    idle_cycle();
    do_op(0, 0, 1, 32'h0000_0500, 32'h1111_2222, 1);
    idle_cycle();
    do_op(0, 1, 0, 32'h0000_0500, '0, 1);

    // Randomized traffic over a small pool of words.
    foreach (pool[i]) begin
      idle_cycle();
      do_op(0, 0, 1, {13'h0, pool[i], 2'b00}, $urandom(), 0);
    end
    for (int n = 0; n < 40; n++) begin
      int op;
      bit b2b;
      r = $urandom();
      a = {r[31:19], pool[$urandom_range(0, 7)], r[1:0]};
      op = $urandom_range(0, 3);
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) idle_cycle();
      do_op(b2b, op != 2, op >= 2, a, $urandom(), $urandom_range(0, 4) == 0);
    end

    // Reset during the HIGH phase of a write.
    idle_cycle();
    old = ref_word[4];
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h1357_9BDF);
    #1;
    repeat (PC0 + 1) begin @(posedge clk); #1; end
    chk("pre_rst_we_n", wen0, 0);
    chk("pre_rst_sa", sa0, 18'h00009);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    chk("mid_rst_we_n", wen0, 1);
    chk("mid_rst_oe", oe0, 0);
    chk("mid_rst_rdata", rdata0, 0);
    chk("mid_rst_sa", sa0, 0);
    chk("mid_rst_ready", rdy0, 1);
    @(posedge clk); #1;
    chk("hold_rst_we_n", wen0, 1);
    rst = 1'b1;
    ref_rd[0] = '0; ref_rd[1] = '0;
    last_sa[0] = '0; last_sa[1] = '0;
    ref_word[4] = {old[31:16], 16'h9BDF};
    chk("rst_mem_lo", sram0[18'h00008], 16'h9BDF);
    chk("rst_mem_hi", sram0[18'h00009], old[31:16]);
    idle_cycle();
    do_op(0, 1, 0, 32'h0000_0010, '0, 0);

    // PHASE_CYCLES=1 instance: reads only, including the top word.
    sel = 1'b1;
    idle_cycle();
    do_op(0, 1, 0, 32'h0007_FFFC, '0, 0);
    chk("top_rdata", rdata1, 32'hF00D_C0DE);
    do_op(1, 1, 0, 32'h0000_0020, '0, 0);
    for (int n = 0; n < 6; n++) begin
      int pick;
      pick = $urandom_range(0, 3);
      r = $urandom();
      a = (pick == 0) ? 32'h0007_FFFC : (pick == 1) ? 32'h0000_0020 :
          (pick == 2) ? 32'h0002_AAA8 : 32'h0000_0000;
      a = {r[31:19], a[18:2], r[1:0]};
      if (r[5]) idle_cycle();
      do_op(!r[5], 1, 0, a, '0, r[7:6] == 2'b00);
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
